// File: rtl/lsb_mem_port_if.sv
`default_nettype none
// ============================================================================
// Module   : lsb_mem_port_if
// Purpose  : LSB request channel, load CDB and byte-wide RAM/IO port bundle.
// Revision : 1.0
// ============================================================================
interface lsb_mem_port_if;
    logic        rdy;
    logic        jump_wrong_stall;
    logic        lsb_req_flag;
    logic        lsb_req_type;
    logic [1:0]  lsb_req_width;
    logic        lsb_req_sext;
    logic [31:0] lsb_req_addr;
    logic [31:0] lsb_req_data;
    logic [31:0] lsb_req_rob_id;
    logic        lsb_done_flag;
    logic        ld_cdb_flag;
    logic [31:0] ld_cdb_rob_id;
    logic [31:0] ld_cdb_val;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport master (
        output rdy, jump_wrong_stall, lsb_req_flag, lsb_req_type, lsb_req_width,
               lsb_req_sext, lsb_req_addr, lsb_req_data, lsb_req_rob_id,
               mem_din, io_buffer_full,
        input  lsb_done_flag, ld_cdb_flag, ld_cdb_rob_id, ld_cdb_val,
               mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  rdy, jump_wrong_stall, lsb_req_flag, lsb_req_type, lsb_req_width,
               lsb_req_sext, lsb_req_addr, lsb_req_data, lsb_req_rob_id,
               mem_din, io_buffer_full,
        output lsb_done_flag, ld_cdb_flag, ld_cdb_rob_id, ld_cdb_val,
               mem_dout, mem_a, mem_wr
    );
endinterface
`default_nettype wire

// File: rtl/lsb_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : lsb_mem_port
// Purpose  : Byte-serial RAM/IO responder for LSB requests with load CDB output.
// Revision : 1.0
// ============================================================================
module lsb_mem_port #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic          clk,
    input  logic          rst,
    lsb_mem_port_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_IO = 2'd1,
        S_XFER    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state_q;
    logic        type_q;
    logic [1:0]  width_q;
    logic        sext_q;
    logic        io_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] rob_q;
    logic [2:0]  cnt_q;
    logic        kill_q;
    logic [31:0] res_q;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q;
    logic        done_q;
    logic        cdb_flag_q;
    logic [31:0] cdb_rob_q;
    logic [31:0] cdb_val_q;

    logic [2:0]  cnt_nx;
    logic [2:0]  n_last;
    logic [31:0] res_d;
    logic [31:0] ext_d;
    logic        wr_ok;
    logic        req_io;

    function automatic logic [7:0] sel_byte(input logic [31:0] d, input logic [1:0] i);
        return d[{i, 3'b000} +: 8];
    endfunction

    always_comb begin
        cnt_nx = cnt_q + 3'd1;
        case (width_q)
            2'b00:   n_last = 3'd0;
            2'b01:   n_last = 3'd1;
            default: n_last = 3'd3;
        endcase
        // mem_din holds the byte addressed one cycle earlier, i.e. byte cnt-1
        res_d = res_q;
        case (cnt_q)
            3'd1:    res_d[7:0]   = bus.mem_din;
            3'd2:    res_d[15:8]  = bus.mem_din;
            3'd3:    res_d[23:16] = bus.mem_din;
            3'd4:    res_d[31:24] = bus.mem_din;
            default: res_d = res_q;
        endcase
        case (width_q)
            2'b00:   ext_d = sext_q ? {{24{res_d[7]}}, res_d[7:0]} : {24'd0, res_d[7:0]};
            2'b01:   ext_d = sext_q ? {{16{res_d[15]}}, res_d[15:0]} : {16'd0, res_d[15:0]};
            default: ext_d = res_d;
        endcase
        wr_ok  = ~io_q | ~bus.io_buffer_full;
        req_io = bus.lsb_req_type && (bus.lsb_req_addr[17:16] == IO_SEL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            type_q     <= 1'b0;
            width_q    <= 2'b00;
            sext_q     <= 1'b0;
            io_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rob_q      <= '0;
            cnt_q      <= '0;
            kill_q     <= 1'b0;
            res_q      <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            cdb_flag_q <= 1'b0;
            cdb_rob_q  <= '0;
            cdb_val_q  <= '0;
        end else if (!bus.rdy) begin
            // Frozen: a store byte whose write was suppressed is re-driven on resume
            mem_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            cdb_flag_q <= 1'b0;
        end else begin
            mem_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            cdb_flag_q <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (bus.lsb_req_flag) begin
                        type_q  <= bus.lsb_req_type;
                        width_q <= bus.lsb_req_width;
                        sext_q  <= bus.lsb_req_sext;
                        io_q    <= req_io;
                        addr_q  <= bus.lsb_req_addr;
                        data_q  <= bus.lsb_req_data;
                        rob_q   <= bus.lsb_req_rob_id;
                        cnt_q   <= '0;
                        kill_q  <= 1'b0;
                        res_q   <= '0;
                        if (req_io) begin
                            state_q <= S_WAIT_IO;
                        end else begin
                            state_q <= S_XFER;
                            mem_a_q <= bus.lsb_req_addr;
                            if (bus.lsb_req_type) begin
                                mem_dout_q <= bus.lsb_req_data[7:0];
                                mem_wr_q   <= 1'b1;
                            end
                        end
                    end
                end
                S_WAIT_IO: begin
                    if (!bus.io_buffer_full) begin
                        state_q    <= S_XFER;
                        mem_a_q    <= addr_q;
                        mem_dout_q <= data_q[7:0];
                        mem_wr_q   <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (type_q) begin
                        if (mem_wr_q && (cnt_q == n_last)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (mem_wr_q) begin
                            cnt_q      <= cnt_nx;
                            mem_a_q    <= addr_q + {29'd0, cnt_nx};
                            mem_dout_q <= sel_byte(data_q, cnt_nx[1:0]);
                            mem_wr_q   <= wr_ok;
                        end else begin
                            mem_a_q    <= addr_q + {29'd0, cnt_q};
                            mem_dout_q <= sel_byte(data_q, cnt_q[1:0]);
                            mem_wr_q   <= wr_ok;
                        end
                    end else begin
                        if (bus.jump_wrong_stall) begin
                            kill_q <= 1'b1;
                        end
                        res_q <= res_d;
                        if (cnt_q == n_last + 3'd1) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cdb_flag_q <= ~(kill_q | bus.jump_wrong_stall);
                            cdb_rob_q  <= rob_q;
                            cdb_val_q  <= ext_d;
                        end else begin
                            cnt_q <= cnt_nx;
                            if (cnt_nx <= n_last) begin
                                mem_a_q <= addr_q + {29'd0, cnt_nx};
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.lsb_done_flag = done_q;
    assign bus.ld_cdb_flag   = cdb_flag_q;
    assign bus.ld_cdb_rob_id = cdb_rob_q;
    assign bus.ld_cdb_val    = cdb_val_q;
    assign bus.mem_a         = mem_a_q;
    assign bus.mem_dout      = mem_dout_q;
    assign bus.mem_wr        = mem_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_lsb_mem_port.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lsb_mem_port
// Purpose  : Vector table, corner sequences and randomized traffic for lsb_mem_port.
// Revision : 1.0
// ============================================================================
module tb_lsb_mem_port;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    lsb_mem_port_if bus();

    lsb_mem_port #(.IO_SEL(2'b11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment RAM: frozen together with the core while rdy is low
    logic [7:0]  ram    [0:4095];
    logic [7:0]  shadow [0:4095];
    logic        pl_req = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_req) begin
            for (int k = 0; k < 4; k++) ram[pl_addr + 12'(k)] = pl_data[8*k +: 8];
        end
        if (bus.rdy) begin
            if (bus.mem_wr && bus.mem_a[17:16] != 2'b11) ram[bus.mem_a[11:0]] = bus.mem_dout;
            bus.mem_din <= ram[bus.mem_a[11:0]];
        end
    end

    typedef struct {
        bit          typ;
        logic [1:0]  w;
        bit          sx;
        bit          pre;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ev;
        int          lat;
    } vec_t;

    vec_t         tv [11];
    logic [39:0]  wq [$];
    logic [31:0]  at [$];
    int           lat, n_done, n_cdb, wr_full;
    bit           kill_exp;
    logic [31:0]  cv, cr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] w, input bit sx, input logic [11:0] a);
        longint raw = 0;
        int     n = nbytes(w);
        for (int k = 0; k < n; k++) raw += longint'(shadow[a + 12'(k)]) << (8*k);
        if (sx && n < 4 && raw >= (longint'(1) << (8*n - 1))) raw -= (longint'(1) << (8*n));
        return raw[31:0];
    endfunction

    task automatic preload(input logic [11:0] a, input logic [31:0] w);
        @(negedge clk);
        pl_addr = a;
        pl_data = w;
        pl_req  = 1'b1;
        @(negedge clk);
        pl_req  = 1'b0;
        for (int k = 0; k < 4; k++) shadow[a + 12'(k)] = w[8*k +: 8];
    endtask

    // Compare captured writes with the bytes the store should produce, then commit to the model
    task automatic check_store(input string name, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        int n = nbytes(w);
        chk({name, " wr count"}, wq.size(), n);
        for (int k = 0; k < n && k < wq.size(); k++)
            chk({name, " wr"}, wq[k], {a + 32'(k), d[8*k +: 8]});
        if (a[17:16] != 2'b11)
            for (int k = 0; k < n; k++) shadow[a[11:0] + 12'(k)] = d[8*k +: 8];
    endtask

    task automatic run_txn(input bit typ, input logic [1:0] w, input bit sx, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rob, input bit hold,
                           input bit rnd, input int flush_at, input int full_cyc);
        int t;
        bit seen = 1'b0;
        wq.delete();
        at.delete();
        n_done = 0; n_cdb = 0; lat = -1; kill_exp = 1'b0; wr_full = 0;
        cv = '0; cr = '0;
        @(negedge clk);
        bus.rdy = 1'b1;
        bus.jump_wrong_stall = 1'b0;
        bus.io_buffer_full = (full_cyc > 0);
        bus.lsb_req_flag = 1'b1;
        bus.lsb_req_type = typ;
        bus.lsb_req_width = w;
        bus.lsb_req_sext = sx;
        bus.lsb_req_addr = a;
        bus.lsb_req_data = d;
        bus.lsb_req_rob_id = rob;
        t = cyc;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (!hold) bus.lsb_req_flag = 1'b0;
            bus.io_buffer_full = (i < full_cyc);
            if (bus.lsb_done_flag) begin
                seen = 1'b1;
                n_done++;
                lat = cyc - t;
                bus.rdy = 1'b1;
                bus.jump_wrong_stall = 1'b0;
            end else if (rnd) begin
                bus.rdy = ($urandom_range(0, 5) != 0);
                bus.jump_wrong_stall = !typ && ($urandom_range(0, 15) == 0);
                if (bus.rdy && bus.jump_wrong_stall) kill_exp = 1'b1;
            end else begin
                bus.jump_wrong_stall = (i == flush_at);
                if (bus.jump_wrong_stall) kill_exp = 1'b1;
            end
            if (bus.ld_cdb_flag) begin
                n_cdb++;
                cv = bus.ld_cdb_val;
                cr = bus.ld_cdb_rob_id;
            end
            if (bus.mem_wr && bus.rdy) begin
                wq.push_back({bus.mem_a, bus.mem_dout});
                if (bus.io_buffer_full) wr_full++;
            end
            at.push_back(bus.mem_a);
        end
        if (!seen) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout: no done pulse within 60 cycles, required one");
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.lsb_req_flag = 1'b0;
            bus.rdy = 1'b1;
            bus.jump_wrong_stall = 1'b0;
            bus.io_buffer_full = 1'b0;
            if (bus.lsb_done_flag) n_done++;
            if (bus.ld_cdb_flag) n_cdb++;
            if (bus.mem_wr) wq.push_back({bus.mem_a, bus.mem_dout});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        bit          typ, sx;
        logic [1:0]  w;
        logic [31:0] a, d, rob, ev;
        int          k_ext;

        tv[0]  = '{1'b0, 2'b11, 1'b0, 1'b1, 32'h100, 32'h44332211, 32'h44332211, 6};
        tv[1]  = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h010, 32'h00000080, 32'hFFFFFF80, 3};
        tv[2]  = '{1'b0, 2'b00, 1'b0, 1'b0, 32'h010, 32'h0,        32'h00000080, 3};
        tv[3]  = '{1'b0, 2'b01, 1'b1, 1'b1, 32'h020, 32'h00008001, 32'hFFFF8001, 4};
        tv[4]  = '{1'b0, 2'b01, 1'b1, 1'b1, 32'h024, 32'h00007FFF, 32'h00007FFF, 4};
        tv[5]  = '{1'b1, 2'b01, 1'b0, 1'b0, 32'h200, 32'hABCD1234, 32'h0,        3};
        tv[6]  = '{1'b0, 2'b01, 1'b0, 1'b0, 32'h200, 32'h0,        32'h00001234, 4};
        tv[7]  = '{1'b1, 2'b11, 1'b0, 1'b0, 32'h300, 32'hDEADBEEF, 32'h0,        5};
        tv[8]  = '{1'b0, 2'b10, 1'b1, 1'b0, 32'h300, 32'h0,        32'hDEADBEEF, 6};
        tv[9]  = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h303, 32'h0,        32'hFFFFFFDE, 3};
        tv[10] = '{1'b0, 2'b01, 1'b0, 1'b0, 32'h302, 32'h0,        32'h0000DEAD, 4};

        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.jump_wrong_stall = 1'b0;
        bus.lsb_req_flag = 1'b0;
        bus.lsb_req_type = 1'b0;
        bus.lsb_req_width = 2'b00;
        bus.lsb_req_sext = 1'b0;
        bus.lsb_req_addr = '0;
        bus.lsb_req_data = '0;
        bus.lsb_req_rob_id = '0;
        bus.io_buffer_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset done", bus.lsb_done_flag, 0);
        chk("reset cdb", bus.ld_cdb_flag, 0);
        chk("reset cdb rob", bus.ld_cdb_rob_id, 0);
        chk("reset cdb val", bus.ld_cdb_val, 0);
        chk("reset mem_a", bus.mem_a, 0);
        chk("reset mem_dout", bus.mem_dout, 0);
        chk("reset mem_wr", bus.mem_wr, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            if (tv[i].pre) preload(tv[i].a[11:0], tv[i].d);
            rob = 32'h1000 + 32'(i);
            run_txn(tv[i].typ, tv[i].w, tv[i].sx, tv[i].a, tv[i].d, rob, 1'b0, 1'b0, -1, 0);
            chk("vec latency", lat, tv[i].lat);
            chk("vec done count", n_done, 1);
            chk("vec cdb count", n_cdb, tv[i].typ ? 0 : 1);
            if (tv[i].typ) begin
                check_store("vec store", tv[i].w, tv[i].a, tv[i].d);
            end else begin
                chk("vec load val", cv, tv[i].ev);
                chk("vec load rob", cr, rob);
                chk("vec load no wr", wq.size(), 0);
            end
        end

        // Word load address sequence
        run_txn(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h77, 1'b0, 1'b0, -1, 0);
        for (int k = 0; k < 4; k++) chk("lw mem_a seq", at[k], 32'h100 + 32'(k));

        // Request held high through DONE must not restart
        run_txn(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h55, 1'b1, 1'b0, -1, 0);
        chk("held done count", n_done, 1);
        chk("held cdb count", n_cdb, 1);
        chk("held val", cv, 32'h44332211);
        chk("held latency", lat, 6);

        // I/O store stalled by a full sink for three cycles
        run_txn(1'b1, 2'b00, 1'b0, 32'h30000, 32'h41, 32'h9, 1'b0, 1'b0, -1, 3);
        chk("io wr while full", wr_full, 0);
        chk("io done count", n_done, 1);
        chk("io cdb count", n_cdb, 0);
        chk("io latency", lat, 6);
        check_store("io store", 2'b00, 32'h30000, 32'h41);

        // Flush during a word load
        run_txn(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h66, 1'b0, 1'b0, 1, 0);
        chk("flush done count", n_done, 1);
        chk("flush cdb count", n_cdb, 0);

        // Reset in the middle of a word load
        preload(12'h500, 32'hCAFEF00D);
        @(negedge clk);
        bus.lsb_req_flag = 1'b1;
        bus.lsb_req_type = 1'b0;
        bus.lsb_req_width = 2'b11;
        bus.lsb_req_addr = 32'h500;
        bus.lsb_req_rob_id = 32'h44;
        @(negedge clk);
        bus.lsb_req_flag = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst mem_a", bus.mem_a, 0);
        chk("rst mem_wr", bus.mem_wr, 0);
        chk("rst done", bus.lsb_done_flag, 0);
        k_ext = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.lsb_done_flag || bus.ld_cdb_flag || bus.mem_a != 0) k_ext++;
        end
        chk("rst stays idle", k_ext, 0);
        run_txn(1'b0, 2'b11, 1'b0, 32'h500, 32'h0, 32'h45, 1'b0, 1'b0, -1, 0);
        chk("post rst val", cv, 32'hCAFEF00D);
        chk("post rst rob", cr, 32'h45);
        chk("post rst done", n_done, 1);

        // Randomized traffic with rdy stalls and flushes against the shadow model
        for (int i = 0; i < 64; i++) preload(12'h400 + 12'(4*i), $urandom);
        for (int i = 0; i < 40; i++) begin
            typ = 1'($urandom_range(0, 1));
            w   = 2'($urandom_range(0, 3));
            sx  = 1'($urandom_range(0, 1));
            a   = 32'h400 + 32'($urandom_range(0, 252));
            d   = $urandom;
            rob = $urandom;
            ev  = model_load(w, sx, a[11:0]);
            run_txn(typ, w, sx, a, d, rob, 1'b0, 1'b1, -1, 0);
            chk("rnd done count", n_done, 1);
            chk("rnd cdb count", n_cdb, (!typ && !kill_exp) ? 1 : 0);
            if (typ) begin
                check_store("rnd store", w, a, d);
            end else begin
                chk("rnd load no wr", wq.size(), 0);
                if (!kill_exp) begin
                    chk("rnd load val", cv, ev);
                    chk("rnd load rob", cr, rob);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
